regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (RegWrite/wr/wd) between two writeback requesters:
//  ALU results (req A) and load results (req B).
//  Each requester has a QDEPTH-entry FIFO with a valid/ready handshake.
//  One queued write is granted per cycle and driven to the register file from registered outputs.
//  Exports a pending-write mask so decode can stall on read-after-write against queued results.
// PARAMETERS
//  DW      32  write-data width
//  AW      5   register-index width (2**AW registers)
//  QDEPTH  2   entries per requester FIFO; power of two, >= 2
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  a_valid     in   1       ALU write request valid
//  a_rd        in   AW      ALU destination register
//  a_data      in   DW      ALU write data
//  a_ready     out  1       ALU FIFO can accept (not full)
//  b_valid     in   1       load write request valid
//  b_rd        in   AW      load destination register
//  b_data      in   DW      load write data
//  b_ready     out  1       load FIFO can accept (not full)
//  rf_we       out  1       to register file RegWrite, one-cycle pulse per write
//  rf_wr       out  AW      to register file wr
//  rf_wd       out  DW      to register file wd
//  pend_mask   out  2**AW   bit r set = write to r queued or on rf_* this cycle
// BEHAVIOUR
//  - Reset (async assert, sync release): both FIFOs emptied, rf_we=0, rf_wr=0, rf_wd=0,
//    pend_mask=0, a_ready=b_ready=1, priority pointer = A.
//  - Push: x_valid && x_ready at clock edge -> entry {rd,data} appended to FIFO x.
//  - x_ready = !full(x) only; no pass-through, so a full FIFO stays not-ready even in a pop cycle.
//  - rd==0 requests: handshake completes normally, entry is not stored, never reaches rf_we,
//    and never sets pend_mask.
//  - Grant: each cycle, if any FIFO is non-empty, pop one head.
//    Popped entry is registered onto rf_we=1/rf_wr/rf_wd next cycle; otherwise rf_we=0.
//    rf_wr/rf_wd hold their last value while rf_we=0.
//  - Latency: push at edge N -> earliest rf_we at edge N+2 (N+1 entry at head and popped,
//    N+2 rf_* valid). Throughput 1 write/cycle aggregate.
//  - Simultaneous push and pop on the same FIFO: both occur, occupancy unchanged.
//    Wrap-around of read/write pointers uses modulo-QDEPTH indices plus a full/empty count.
//  - pend_mask is combinational OR of decoded rd over all valid FIFO entries and over
//    rf_wr when rf_we=1. A register in both FIFOs shows a single set bit.
//  - Ordering: writes from the same requester retire in push order.
//    No ordering between A and B; requesters must not both hold the same rd
//    (decode enforces this with pend_mask).
//  - Reset asserted mid-operation: all queued writes discarded, an rf_we pulse in progress
//    is dropped immediately.
// CONFIGURATION
//  - WB_RR_FAIR_EN defined: round-robin.
//    When both FIFOs are non-empty, grant the side not granted last.
//    The pointer updates only on contested grants. Uncontested grants take the only
//    non-empty side and leave the pointer unchanged.
//  - WB_RR_FAIR_EN undefined: fixed priority, A (ALU) always wins when non-empty;
//    B is granted only when A is empty. The pointer register is not built.
// TESTING
//  - Single write: A push rd=5 data=0x4 -> two cycles later rf_we=1, rf_wr=5, rf_wd=0x4
//    for exactly 1 cycle; pend_mask[5] set from push+1 until rf_we falls.
//  - x0 drop: B push rd=0 data=0xFFFF_FFFF -> b_ready stays 1, rf_we never asserts,
//    pend_mask stays 0.
//  - Full/backpressure: hold a_valid 4 cycles with B idle, QDEPTH=2 ->
//    every push accepted at 1/cycle, a_ready stays 1, writes retire in order.
//    Hold a_valid and b_valid for 4 cycles with pops going to the other side ->
//    the starved FIFO fills, its ready drops after 2 accepts and rises the cycle after its
//    first pop; all writes retire in push order.
//  - Contention: A and B each push 3 writes (A rd=1,2,3; B rd=9,10,11) together ->
//    with WB_RR_FAIR_EN: rf_wr = 1,9,2,10,3,11;
//    without: rf_wr = 1,2,3,9,10,11.
//  - Reset mid-flight: 2 entries queued in each FIFO, drop rst_n for 1 cycle ->
//    rf_we=0 immediately, pend_mask=0, both readys=1, no stale write after release.
//  - Same-cycle push/pop: A streams 1 push/cycle for 8 cycles, B idle ->
//    a_ready never drops, 8 consecutive rf_we pulses in order.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between two writeback
//   requesters: ALU results (side A) and load results (side B). Each side
//   owns a QDEPTH-entry FIFO behind a valid/ready handshake. One queued write
//   is popped per cycle into a grant stage, then driven to the register file
//   from registered outputs (push at edge N -> rf_we at edge N+2).
//   pend_mask flags every register with a write still in flight so decode
//   can stall on read-after-write hazards.
//
//   Build option: define WB_RR_FAIR_EN for round-robin arbitration on
//   contested cycles; otherwise fixed priority with A always winning.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   a_valid/a_rd/a_data/a_ready ALU writeback request channel
//   b_valid/b_rd/b_data/b_ready load writeback request channel
//   rf_we/rf_wr/rf_wd           register-file write port (registered)
//   pend_mask                   per-register pending-write flags
module regfile_wb_arbiter #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned QDEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  input  logic [AW-1:0]        a_rd,
  input  logic [DW-1:0]        a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [AW-1:0]        b_rd,
  input  logic [DW-1:0]        b_data,
  output logic                 b_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wr,
  output logic [DW-1:0]        rf_wd,
  output logic [(2**AW)-1:0]   pend_mask
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned NS = 2;

  // Per-side FIFO storage; index 0 is A, index 1 is B.
  logic [AW-1:0] mem_rd   [NS][QDEPTH];
  logic [DW-1:0] mem_data [NS][QDEPTH];
  logic [PW-1:0] wr_ptr   [NS];
  logic [PW-1:0] rd_ptr   [NS];
  logic [CW-1:0] cnt      [NS];

  logic [NS-1:0] in_valid;
  logic [AW-1:0] in_rd   [NS];
  logic [DW-1:0] in_data [NS];
  logic [NS-1:0] full;
  logic [NS-1:0] nonempty;
  logic [NS-1:0] push;
  logic [NS-1:0] pop;

  // Grant stage between the FIFO pop and the register-file outputs.
  logic          g_valid;
  logic [AW-1:0] g_rd;
  logic [DW-1:0] g_data;

  // Request channel fan-in into side-indexed form.
  always_comb begin
    in_valid   = {b_valid, a_valid};
    in_rd[0]   = a_rd;
    in_rd[1]   = b_rd;
    in_data[0] = a_data;
    in_data[1] = b_data;
  end

  // Occupancy flags and handshake; x0 writes complete but are never stored.
  always_comb begin
    full     = '0;
    nonempty = '0;
    push     = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      full[s]     = (cnt[s] == CW'(QDEPTH));
      nonempty[s] = (cnt[s] != '0);
      push[s]     = in_valid[s] && !full[s] && (in_rd[s] != '0);
    end
  end

  assign a_ready = !full[0];
  assign b_ready = !full[1];

  // Arbitration between the two FIFO heads.
`ifdef WB_RR_FAIR_EN
  logic prio_b;

  always_comb begin
    pop = '0;
    if (nonempty[0] && nonempty[1]) begin
      pop[0] = !prio_b;
      pop[1] = prio_b;
    end else begin
      pop[0] = nonempty[0];
      pop[1] = !nonempty[0] && nonempty[1];
    end
  end

  // Pointer only moves on contested grants, toward the side that lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_b <= 1'b0;
    end else if (nonempty[0] && nonempty[1]) begin
      prio_b <= !prio_b;
    end
  end
`else
  always_comb begin
    pop    = '0;
    pop[0] = nonempty[0];
    pop[1] = !nonempty[0] && nonempty[1];
  end
`endif

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NS; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < NS; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PW'(1);
        case ({push[s], pop[s]})
          2'b10:   cnt[s] <= cnt[s] + CW'(1);
          2'b01:   cnt[s] <= cnt[s] - CW'(1);
          default: cnt[s] <= cnt[s];
        endcase
      end
    end
  end

  // FIFO payload storage; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < NS; s++) begin
      if (push[s]) begin
        mem_rd[s][wr_ptr[s]]   <= in_rd[s];
        mem_data[s][wr_ptr[s]] <= in_data[s];
      end
    end
  end

  // Grant stage and register-file port; rf_wr/rf_wd hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_valid <= 1'b0;
      g_rd    <= '0;
      g_data  <= '0;
      rf_we   <= 1'b0;
      rf_wr   <= '0;
      rf_wd   <= '0;
    end else begin
      g_valid <= |pop;
      if (pop[0]) begin
        g_rd   <= mem_rd[0][rd_ptr[0]];
        g_data <= mem_data[0][rd_ptr[0]];
      end else if (pop[1]) begin
        g_rd   <= mem_rd[1][rd_ptr[1]];
        g_data <= mem_data[1][rd_ptr[1]];
      end
      rf_we <= g_valid;
      if (g_valid) begin
        rf_wr <= g_rd;
        rf_wd <= g_data;
      end
    end
  end

  // Pending mask: live FIFO entries, the grant stage, and the write on rf_*.
  always_comb begin
    pend_mask = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        // Entry i is live when its distance from the read pointer is < count.
        if (CW'(PW'(PW'(i) - rd_ptr[s])) < cnt[s]) begin
          pend_mask[mem_rd[s][i]] = 1'b1;
        end
      end
    end
    if (g_valid) pend_mask[g_rd]  = 1'b1;
    if (rf_we)   pend_mask[rf_wr] = 1'b1;
  end

endmodule
